// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and key decode for the TM1638 key reader.
package tm1638_pkg;

  localparam logic [7:0] TM1638_CMD_READ_KEYS = 8'h42;
  localparam int         TM1638_SCAN_BYTES    = 4;
  localparam int         TM1638_SCAN_BITS     = TM1638_SCAN_BYTES * 8;
  localparam int         TM1638_TMR_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_WAIT,
    ST_READ,
    ST_HOLD
  } tm1638_state_e;

  // Each scan byte carries two keys: bit 0 and bit 4.
  function automatic logic [7:0] tm1638_decode_keys(input logic [TM1638_SCAN_BITS-1:0] scan);
    logic [7:0] k_vec;
    k_vec = '0;
    for (int k = 0; k < TM1638_SCAN_BYTES; k++) begin
      k_vec[2*k]   = scan[8*k];
      k_vec[2*k+1] = scan[8*k+4];
    end
    return k_vec;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Half-period down-counter for the TM1638 serial clock. Also serves as a
// one-shot delay: a start loads an arbitrary length and initial phase.
module tm1638_bit_timer
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [TM1638_TMR_W-1:0] start_len,
  input  logic                    start_high,
  input  logic                    park,
  output logic                    half_end,
  output logic                    phase_high,
  output logic                    sample_en
);

  localparam logic [TM1638_TMR_W-1:0] HALF_RELOAD = TM1638_TMR_W'(CLK_DIV - 1);
  localparam logic [TM1638_TMR_W-1:0] ONE         = TM1638_TMR_W'(1);

  logic [TM1638_TMR_W-1:0] cnt;

  assign half_end  = (cnt == '0);
  assign sample_en = half_end & phase_high;

  // Counter and phase: start wins, park holds the line high, otherwise toggle on terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= HALF_RELOAD;
      phase_high <= 1'b1;
    end else if (start) begin
      cnt        <= start_len - ONE;
      phase_high <= start_high;
    end else if (park) begin
      cnt        <= HALF_RELOAD;
      phase_high <= 1'b1;
    end else if (half_end) begin
      cnt        <= HALF_RELOAD;
      phase_high <= ~phase_high;
    end else begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends READ_KEYS, turns DIO around and shifts in
// four scan bytes, then publishes raw bytes and decoded key state.
//
// state | meaning
// IDLE  | pins parked, waiting for scan_req
// SETUP | stb low, first command bit on DIO
// CMD   | shifting 0x42 out, LSB first
// WAIT  | DIO released, turnaround delay
// READ  | clocking in 32 scan bits, LSB first
// HOLD  | stb low, clk high before release
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int WAIT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_req,
  output logic        busy,
  output logic [7:0]  keys,
  output logic [31:0] raw,
  output logic        keys_valid,
  output logic        tm1638_stb,
  output logic        tm1638_clk,
  output logic        tm1638_dio_out,
  output logic        tm1638_dio_oe,
  input  logic        tm1638_dio_in
);

  localparam logic [TM1638_TMR_W-1:0] LEN_HALF      = TM1638_TMR_W'(CLK_DIV);
  localparam logic [TM1638_TMR_W-1:0] LEN_WAIT      = TM1638_TMR_W'(WAIT_CYCLES);
  localparam logic [5:0]              LAST_CMD_BIT  = 6'd7;
  localparam logic [5:0]              LAST_READ_BIT = 6'(TM1638_SCAN_BITS - 1);

  tm1638_state_e                state, state_nxt;
  logic [5:0]                   bit_cnt, bit_cnt_nxt;
  logic [TM1638_SCAN_BITS-1:0]  shift, shift_nxt;
  logic                         dio_out_nxt;
  logic                         load_nxt;
  logic                         dio_meta, dio_sync;
  logic                         tmr_start, tmr_high, tmr_park;
  logic [TM1638_TMR_W-1:0]      tmr_len;
  logic                         half_end, phase_high, sample_en;

  tm1638_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tmr_start),
    .start_len  (tmr_len),
    .start_high (tmr_high),
    .park       (tmr_park),
    .half_end   (half_end),
    .phase_high (phase_high),
    .sample_en  (sample_en)
  );

  // The timer phase flop is the serial clock itself, so the pin never glitches.
  assign tm1638_clk = phase_high;

  // Two-flop synchronizer for the asynchronous DIO pad.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dio_meta <= 1'b1;
      dio_sync <= 1'b1;
    end else begin
      dio_meta <= tm1638_dio_in;
      dio_sync <= dio_meta;
    end
  end

  // Next-state, timer control, shift and DIO drive decisions.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    dio_out_nxt = tm1638_dio_out;
    load_nxt    = 1'b0;
    tmr_start   = 1'b0;
    tmr_len     = LEN_HALF;
    tmr_high    = 1'b1;
    tmr_park    = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_park = 1'b1;
        if (scan_req) begin
          state_nxt   = ST_SETUP;
          tmr_start   = 1'b1;
          dio_out_nxt = TM1638_CMD_READ_KEYS[0];
        end
      end
      ST_SETUP: begin
        if (half_end) begin
          state_nxt   = ST_CMD;
          tmr_start   = 1'b1;
          tmr_high    = 1'b0;
          bit_cnt_nxt = '0;
        end
      end
      ST_CMD: begin
        if (sample_en) begin
          if (bit_cnt == LAST_CMD_BIT) begin
            state_nxt   = ST_WAIT;
            tmr_start   = 1'b1;
            tmr_len     = LEN_WAIT;
            dio_out_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
            dio_out_nxt = TM1638_CMD_READ_KEYS[bit_cnt_nxt[2:0]];
          end
        end
      end
      ST_WAIT: begin
        if (half_end) begin
          state_nxt   = ST_READ;
          tmr_start   = 1'b1;
          tmr_high    = 1'b0;
          bit_cnt_nxt = '0;
        end
      end
      ST_READ: begin
        if (sample_en) begin
          shift_nxt = {dio_sync, shift[TM1638_SCAN_BITS-1:1]};
          if (bit_cnt == LAST_READ_BIT) begin
            state_nxt = ST_HOLD;
            tmr_start = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          state_nxt = ST_IDLE;
          tmr_park  = 1'b1;
          load_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_park  = 1'b1;
      end
    endcase
  end

  // State, datapath and registered pin/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      tm1638_stb     <= 1'b1;
      tm1638_dio_oe  <= 1'b0;
      tm1638_dio_out <= 1'b1;
      busy           <= 1'b0;
      keys_valid     <= 1'b0;
      keys           <= '0;
      raw            <= '0;
    end else begin
      state          <= state_nxt;
      bit_cnt        <= bit_cnt_nxt;
      shift          <= shift_nxt;
      tm1638_stb     <= (state_nxt == ST_IDLE);
      tm1638_dio_oe  <= (state_nxt == ST_SETUP) || (state_nxt == ST_CMD);
      tm1638_dio_out <= dio_out_nxt;
      busy           <= (state_nxt != ST_IDLE);
      keys_valid     <= load_nxt;
      if (load_nxt) begin
        raw  <= shift;
        keys <= tm1638_decode_keys(shift);
      end
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Scoreboard bench for tm1638_key_reader with a behavioural TM1638 chip model.
module tb_tm1638_key_reader;

  localparam int CLK_DIV     = 4;
  localparam int WAIT_CYCLES = 8;
  localparam int LATENCY     = 82 * CLK_DIV + WAIT_CYCLES;
  localparam int OE_CYCLES   = 17 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_req = 1'b0;
  logic        dio_in = 1'b1;
  logic        busy, keys_valid, tm_stb, tm_clk, tm_dio_out, tm_dio_oe;
  logic [7:0]  keys;
  logic [31:0] raw;

  tm1638_key_reader #(
    .CLK_DIV     (CLK_DIV),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scan_req       (scan_req),
    .busy           (busy),
    .keys           (keys),
    .raw            (raw),
    .keys_valid     (keys_valid),
    .tm1638_stb     (tm_stb),
    .tm1638_clk     (tm_clk),
    .tm1638_dio_out (tm_dio_out),
    .tm1638_dio_oe  (tm_dio_oe),
    .tm1638_dio_in  (dio_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: two keys per byte, bit 0 and bit 4 of each byte.
  function automatic logic [7:0] model_keys(input logic [31:0] d);
    logic [7:0] k;
    logic [7:0] b;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      b = d[8*i +: 8];
      k[2*i]   = b[0];
      k[2*i+1] = b[4];
    end
    return k;
  endfunction

  typedef struct {
    logic [31:0] raw;
    logic [7:0]  keys;
  } exp_t;

  logic [31:0] data_q[$];
  exp_t        exp_q[$];

  // TM1638 chip model: captures the command, returns scan data on falling clk.
  logic [31:0] cur_data = '0;
  logic [7:0]  cmd_byte = '0;
  int          rd_idx = 0;
  int          cmd_idx = 0;

  always @(negedge tm_stb) begin
    rd_idx  = 0;
    cmd_idx = 0;
    if (data_q.size() > 0) cur_data = data_q.pop_front();
    else cur_data = '0;
  end

  always @(posedge tm_clk) begin
    if (tm_stb === 1'b0 && tm_dio_oe === 1'b1 && cmd_idx < 8) begin
      cmd_byte[cmd_idx] = tm_dio_out;
      cmd_idx++;
      if (cmd_idx == 8) check("cmd_byte", cmd_byte, 8'h42);
    end
  end

  always @(negedge tm_clk) begin
    if (tm_stb === 1'b0 && tm_dio_oe === 1'b0 && rd_idx < 32) begin
      dio_in = cur_data[rd_idx];
      rd_idx++;
    end
  end

  // Monitor: pops the scoreboard on every keys_valid pulse.
  int   pulse_cnt = 0;
  int   accept_cyc = 0;
  int   last_valid_cyc = 0;
  int   oe_cnt = 0;
  bit   b2b_mode = 1'b0;
  bit   b2b_armed = 1'b0;
  logic prev_stb = 1'b1;
  logic prev_oe = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_stb === 1'b1 && tm_stb === 1'b0) begin
      accept_cyc = cyc;
      if (b2b_armed) check("b2b_gap", cyc - last_valid_cyc, 1);
    end
    if (tm_dio_oe === 1'b1) oe_cnt++;
    if (prev_oe === 1'b1 && tm_dio_oe === 1'b0) begin
      check("dio_oe_width", oe_cnt, OE_CYCLES);
      oe_cnt = 0;
    end
    if (keys_valid === 1'b1) begin
      pulse_cnt++;
      last_valid_cyc = cyc;
      if (b2b_mode) b2b_armed = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_keys_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("raw", raw, e.raw);
        check("keys", keys, e.keys);
        check("latency", cyc - accept_cyc, LATENCY);
        check("busy_before_valid", prev_busy, 1);
        check("stb_rise_with_valid", {prev_stb, tm_stb}, 2'b01);
      end
    end
    prev_stb  = tm_stb;
    prev_oe   = tm_dio_oe;
    prev_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] d, input bit completes);
    exp_t e;
    data_q.push_back(d);
    if (completes) begin
      e.raw  = d;
      e.keys = model_keys(d);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    scan_req = 1'b1;
    @(negedge clk);
    scan_req = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int limit);
    int t;
    t = 0;
    while (pulse_cnt < target && t < limit) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wait_keys_valid", pulse_cnt >= target, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int base;

    // Reset values and quiet idle period.
    rst_n = 1'b0;
    tick(3);
    check("rst_stb", tm_stb, 1);
    check("rst_clk", tm_clk, 1);
    check("rst_dio_oe", tm_dio_oe, 0);
    check("rst_dio_out", tm_dio_out, 1);
    check("rst_busy", busy, 0);
    check("rst_keys", keys, 0);
    check("rst_raw", raw, 0);
    check("rst_valid", keys_valid, 0);
    rst_n = 1'b1;
    tick(20);
    check("idle_no_pulse", pulse_cnt, 0);
    check("idle_stb", tm_stb, 1);

    // Directed decode, plus an ignored request while busy.
    issue(32'h1100_1001, 1'b1);
    pulse_req();
    tick(98);
    check("busy_mid_scan", busy, 1);
    pulse_req();
    wait_pulses(1, 500);
    check("dir_raw", raw, 32'h1100_1001);
    check("dir_keys", keys, 8'hC9);
    tick(400);
    check("single_scan", pulse_cnt, 1);
    check("idle_after_scan", busy, 0);

    // Randomised scans.
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      issue(d, 1'b1);
      pulse_req();
      wait_pulses(2 + i, 500);
      tick($urandom_range(1, 10));
    end

    // Back-to-back scans with scan_req held high.
    base = pulse_cnt;
    issue($urandom, 1'b1);
    issue($urandom, 1'b1);
    d = $urandom | 32'h1;
    issue(d, 1'b1);
    b2b_mode = 1'b1;
    @(negedge clk);
    scan_req = 1'b1;
    wait_pulses(base + 2, 1000);
    @(negedge clk);
    scan_req = 1'b0;
    wait_pulses(base + 3, 500);
    b2b_mode  = 1'b0;
    b2b_armed = 1'b0;
    tick(400);
    check("b2b_three_pulses", pulse_cnt, base + 3);

    // Reset during READ bit 10: no pulse, clean pins, then a normal scan.
    base = pulse_cnt;
    issue($urandom, 1'b0);
    pulse_req();
    tick(76 + 10 * 2 * CLK_DIV + 3 - 1);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    tick(1);
    check("abort_stb", tm_stb, 1);
    check("abort_dio_oe", tm_dio_oe, 0);
    check("abort_keys", keys, 0);
    check("abort_busy", busy, 0);
    rst_n = 1'b1;
    tick(400);
    check("abort_no_pulse", pulse_cnt, base);
    d = $urandom;
    issue(d, 1'b1);
    pulse_req();
    wait_pulses(base + 1, 500);
    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
